fp32_multiplier: RTL and testbench
==================================

// Module: fp32_multiplier
// PURPOSE
//  Multi-cycle IEEE-754 single-precision multiplier; the inverse-operation companion to the FP32 divider.
//  Uses the same En/Ready operand handshake as the divider, so the arithmetic unit muxes both units onto one result bus.
//  Computes the mantissa product with an iterative shift-add loop.
//  Handles special cases with an early-exit path.
// PARAMETERS
//  BITS_PER_CYCLE  1  multiplier bits retired per MULT cycle; legal values 1,2,4,8; ITER = 24/BITS_PER_CYCLE
// PORTS
//  clk     in   1   clock, rising edge
//  reset   in   1   asynchronous, active-low reset
//  A       in   32  multiplicand, FP32; sampled when an En is accepted
//  B       in   32  multiplier, FP32; sampled when an En is accepted
//  En      in   1   start request; accepted only in IDLE or DONE
//  Result  out  32  FP32 product; valid while Ready=1
//  Ready   out  1   result valid; held high until the next En is accepted
//  NaN     out  1   result is NaN; valid while Ready=1
//  Busy    out  1   high from the cycle after En acceptance until Ready rises
// BEHAVIOUR
//  Reset (reset=0, any time): Result=0, Ready=0, NaN=0, Busy=0, state=IDLE; any in-flight operation is discarded.
//  States and transitions:
//   IDLE/DONE --En--> UNPACK; A and B are latched; Ready drops on the next edge.
//   UNPACK: classify operands. A special case goes to PACK; otherwise go to MULT with acc=0, cnt=0.
//   MULT: ITER cycles. acc += ({1,mA} * next BITS_PER_CYCLE bits of {1,mB}), shifted appropriately.
//   MULT: 48-bit product P.
//   NORM: 1 cycle, then PACK.
//   PACK: 1 cycle, then DONE with Ready=1.
//  Latency, counted in edges after the En-accepting edge until Ready=1:
//   normal operands: ITER+3 (27 at the default parameter)
//   special-case operands: 2
//  En while Busy is ignored; the latched operands are not disturbed.
//  En held high in DONE starts a new operation on every acceptance; Ready=1 for exactly one cycle between operations.
//  Sign = A[31]^B[31] for every result except NaN.
//  Exponent arithmetic: 10-bit signed e = eA + eB - 127.
//   If P[47]=1: mant=P[46:24], e+=1. Otherwise mant=P[45:23].
//  Overflow, e>=255 after normalisation/rounding: result ±Inf (7F800000|sign), NaN=0.
//  Underflow, e<=0: result ±0 (flush to zero; no subnormal output).
//  Subnormal inputs (exp=0, frac!=0) are treated as zero.
//  Special-case priority:
//   1. Either operand NaN: 7FC00000, NaN=1.
//   2. Inf*0 or 0*Inf: 7FC00000, NaN=1.
//   3. Inf*finite or Inf*Inf: ±Inf.
//   4. zero*finite: ±0.
//  NaN=0 for every non-NaN result.
//  Rounding default: truncate toward zero; discarded product bits are dropped.
// CONFIGURATION
//  ROUND_NEAREST_EN defined:
//   PACK applies round-to-nearest-even using guard bit plus sticky (OR of the remaining discarded bits).
//   A mantissa carry-out increments e; the overflow check is applied after rounding.
//   Latency is unchanged.
//  ROUND_NEAREST_EN undefined: truncation, with no rounding logic synthesised.
// TESTING
//  1. 3FC00000 * 40000000 -> Result 40400000, NaN=0, Ready exactly 27 edges after the En edge.
//  2. C0000000 * 3F400000 -> BFC00000; 7F800000 * C0000000 -> FF800000, Ready 2 edges after En.
//  3. 3FC00001 * 3FC00001 -> 40100001 without ROUND_NEAREST_EN; 40100002 with it.
//  4. 7F800000 * 00000000 -> 7FC00000, NaN=1; 7FC00000 * 40000000 -> 7FC00000, NaN=1.
//  5. Range limits:
//   7F7FFFFF * 40000000 -> 7F800000, NaN=0.
//   00800000 * 3F000000 -> 00000000.
//   00000001 * 40400000 -> 00000000.
//  6. Handshake and reset:
//   En pulsed mid-MULT -> ignored; the first result is unchanged.
//   reset=0 mid-MULT -> all outputs 0 and IDLE.
//   A new En after reset completes normally.

Source files
------------

// File: rtl/fp32_multiplier.sv
// rtl/fp32_multiplier.sv - multi-cycle FP32 multiplier, shift-add mantissa loop (optional ROUND_NEAREST_EN)
module fp32_multiplier #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        En,
    output logic [31:0] Result,
    output logic        Ready,
    output logic        NaN,
    output logic        Busy
);

    localparam int         ITER     = 24 / BITS_PER_CYCLE;
    localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_MULT,
        S_NORM,
        S_PACK,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic               r_special;
    logic [31:0]        r_spec_res;
    logic               r_spec_nan;
    logic [47:0]        r_acc;
    logic [47:0]        r_ma_sh;
    logic [23:0]        r_mb;
    logic [4:0]         r_cnt;
    logic signed [9:0]  r_exp;
    logic [22:0]        r_mant;
`ifdef ROUND_NEAREST_EN
    logic               r_guard;
    logic               r_sticky;
`endif

    // Operand fields and classification of the latched operands
    logic [7:0]         w_ea;
    logic [7:0]         w_eb;
    logic [22:0]        w_fa;
    logic [22:0]        w_fb;
    logic               w_sign;
    logic               w_a_nan;
    logic               w_b_nan;
    logic               w_a_inf;
    logic               w_b_inf;
    logic               w_a_zero;
    logic               w_b_zero;
    logic [47:0]        w_partial;
    logic [22:0]        w_mant_fin;
    logic signed [9:0]  w_exp_fin;

    assign w_ea     = r_a[30:23];
    assign w_eb     = r_b[30:23];
    assign w_fa     = r_a[22:0];
    assign w_fb     = r_b[22:0];
    assign w_sign   = r_a[31] ^ r_b[31];
    assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'd0);
    assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'd0);
    assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'd0);
    assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'd0);
    // Subnormals are flushed: any zero exponent counts as zero
    assign w_a_zero = (w_ea == 8'h00);
    assign w_b_zero = (w_eb == 8'h00);

    // Partial product for the multiplier bits retired this MULT cycle
    always_comb begin
        w_partial = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (r_mb[k]) begin
                w_partial = w_partial + (r_ma_sh << k);
            end
        end
    end

    // Final mantissa/exponent, with optional round-to-nearest-even
    always_comb begin
        w_mant_fin = r_mant;
        w_exp_fin  = r_exp;
`ifdef ROUND_NEAREST_EN
        if (r_guard && (r_sticky || r_mant[0])) begin
            w_mant_fin = r_mant + 23'd1;
            // All-ones mantissa wraps to zero and carries into the exponent
            if (&r_mant) begin
                w_exp_fin = r_exp + 10'sd1;
            end
        end
`endif
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_special  <= 1'b0;
            r_spec_res <= '0;
            r_spec_nan <= 1'b0;
            r_acc      <= '0;
            r_ma_sh    <= '0;
            r_mb       <= '0;
            r_cnt      <= '0;
            r_exp      <= '0;
            r_mant     <= '0;
`ifdef ROUND_NEAREST_EN
            r_guard    <= 1'b0;
            r_sticky   <= 1'b0;
`endif
            Result     <= '0;
            Ready      <= 1'b0;
            NaN        <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (En) begin
                        r_a     <= A;
                        r_b     <= B;
                        Ready   <= 1'b0;
                        Busy    <= 1'b1;
                        r_state <= S_UNPACK;
                    end
                end

                S_UNPACK: begin
                    r_special  <= 1'b1;
                    r_spec_nan <= 1'b0;
                    if (w_a_nan || w_b_nan) begin
                        r_spec_res <= 32'h7FC0_0000;
                        r_spec_nan <= 1'b1;
                        r_state    <= S_PACK;
                    end else if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
                        r_spec_res <= 32'h7FC0_0000;
                        r_spec_nan <= 1'b1;
                        r_state    <= S_PACK;
                    end else if (w_a_inf || w_b_inf) begin
                        r_spec_res <= {w_sign, 8'hFF, 23'd0};
                        r_state    <= S_PACK;
                    end else if (w_a_zero || w_b_zero) begin
                        r_spec_res <= {w_sign, 31'd0};
                        r_state    <= S_PACK;
                    end else begin
                        r_special <= 1'b0;
                        r_acc     <= '0;
                        r_ma_sh   <= {24'd0, 1'b1, w_fa};
                        r_mb      <= {1'b1, w_fb};
                        r_cnt     <= '0;
                        r_exp     <= 10'(w_ea) + 10'(w_eb) - 10'd127;
                        r_state   <= S_MULT;
                    end
                end

                S_MULT: begin
                    r_acc   <= r_acc + w_partial;
                    r_ma_sh <= r_ma_sh << BITS_PER_CYCLE;
                    r_mb    <= r_mb >> BITS_PER_CYCLE;
                    r_cnt   <= r_cnt + 5'd1;
                    if (r_cnt == LAST_CNT) begin
                        r_state <= S_NORM;
                    end
                end

                S_NORM: begin
                    if (r_acc[47]) begin
                        r_mant   <= r_acc[46:24];
                        r_exp    <= r_exp + 10'sd1;
`ifdef ROUND_NEAREST_EN
                        r_guard  <= r_acc[23];
                        r_sticky <= |r_acc[22:0];
`endif
                    end else begin
                        r_mant   <= r_acc[45:23];
`ifdef ROUND_NEAREST_EN
                        r_guard  <= r_acc[22];
                        r_sticky <= |r_acc[21:0];
`endif
                    end
                    r_state <= S_PACK;
                end

                S_PACK: begin
                    if (r_special) begin
                        Result <= r_spec_res;
                        NaN    <= r_spec_nan;
                    end else if (w_exp_fin >= 10'sd255) begin
                        Result <= {w_sign, 8'hFF, 23'd0};
                        NaN    <= 1'b0;
                    end else if (w_exp_fin <= 10'sd0) begin
                        Result <= {w_sign, 31'd0};
                        NaN    <= 1'b0;
                    end else begin
                        Result <= {w_sign, w_exp_fin[7:0], w_mant_fin};
                        NaN    <= 1'b0;
                    end
                    Ready   <= 1'b1;
                    Busy    <= 1'b0;
                    r_state <= S_DONE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_multiplier.sv
// tb/tb_fp32_multiplier.sv - self-checking bench for fp32_multiplier
module tb_fp32_multiplier;

    localparam int BPC      = 1;
    localparam int LAT_NORM = 24 / BPC + 3;
    localparam int LAT_SPEC = 2;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic        En;
    logic [31:0] Result;
    logic        Ready;
    logic        NaN;
    logic        Busy;

    int n_checks;
    int n_fail;

    fp32_multiplier #(.BITS_PER_CYCLE(BPC)) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .En     (En),
        .Result (Result),
        .Ready  (Ready),
        .NaN    (NaN),
        .Busy   (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        nan;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: returns {nan, result} computed from the IEEE rules with integer arithmetic
    function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int          ea, eb, e, sh;
        logic [22:0] fa, fb;
        logic        s, an, bn, ai, bi, az, bz;
        longint      p, mant;
`ifdef ROUND_NEAREST_EN
        longint      rem, half;
`endif
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = a[22:0];
        fb = b[22:0];
        s  = a[31] ^ b[31];
        an = (ea == 255) && (fa != 0);
        bn = (eb == 255) && (fb != 0);
        ai = (ea == 255) && (fa == 0);
        bi = (eb == 255) && (fb == 0);
        az = (ea == 0);
        bz = (eb == 0);
        if (an || bn) return {1'b1, 32'h7FC00000};
        if ((ai && bz) || (az && bi)) return {1'b1, 32'h7FC00000};
        if (ai || bi) return {1'b0, s, 8'hFF, 23'd0};
        if (az || bz) return {1'b0, s, 31'd0};
        p = (longint'(fa) + 64'sd8388608) * (longint'(fb) + 64'sd8388608);
        e = ea + eb - 127;
        if (p >= (64'sd1 <<< 47)) begin
            sh = 24;
            e  = e + 1;
        end else begin
            sh = 23;
        end
        mant = p >>> sh;
`ifdef ROUND_NEAREST_EN
        rem  = p - (mant <<< sh);
        half = 64'sd1 <<< (sh - 1);
        if (rem > half || (rem == half && (mant % 2) == 1)) mant = mant + 1;
        if (mant >= (64'sd1 <<< 24)) begin
            mant = mant >>> 1;
            e    = e + 1;
        end
`endif
        if (e >= 255) return {1'b0, s, 8'hFF, 23'd0};
        if (e <= 0) return {1'b0, s, 31'd0};
        return {1'b0, s, e[7:0], mant[22:0]};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic nan, output int lat);
        @(negedge clk);
        A  = a;
        B  = b;
        En = 1'b1;
        @(posedge clk);
        #1;
        En  = 1'b0;
        lat = 0;
        while (!Ready && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = Result;
        nan = NaN;
    endtask

    vec_t        vecs[12];
    logic [31:0] res;
    logic        nan;
    int          lat;
    logic [32:0] exp_v;
    logic [31:0] ra, rb;

    initial begin
        vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, LAT_NORM};
        vecs[1]  = '{32'hC0000000, 32'h3F400000, 32'hBFC00000, 1'b0, LAT_NORM};
        vecs[2]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0, LAT_SPEC};
`ifdef ROUND_NEAREST_EN
        vecs[3]  = '{32'h3FC00001, 32'h3FC00001, 32'h40100002, 1'b0, LAT_NORM};
`else
        vecs[3]  = '{32'h3FC00001, 32'h3FC00001, 32'h40100001, 1'b0, LAT_NORM};
`endif
        vecs[4]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1, LAT_SPEC};
        vecs[5]  = '{32'h7FC00000, 32'h40000000, 32'h7FC00000, 1'b1, LAT_SPEC};
        vecs[6]  = '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 1'b0, LAT_NORM};
        vecs[7]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, LAT_NORM};
        vecs[8]  = '{32'h00000001, 32'h40400000, 32'h00000000, 1'b0, LAT_SPEC};
        vecs[9]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, LAT_SPEC};
        vecs[10] = '{32'h00000000, 32'hFF800000, 32'h7FC00000, 1'b1, LAT_SPEC};
        vecs[11] = '{32'hFF800000, 32'hFF800000, 32'h7F800000, 1'b0, LAT_SPEC};

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        A        = '0;
        B        = '0;
        En       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", Result, 32'h0);
        chk("reset_ready", 32'(Ready), 32'h0);
        chk("reset_nan", 32'(NaN), 32'h0);
        chk("reset_busy", 32'(Busy), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, res, nan, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].res);
            chk($sformatf("vec%0d_nan", i), 32'(nan), 32'(vecs[i].nan));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // En pulsed mid-MULT is ignored
        @(negedge clk);
        A  = 32'h3FC00000;
        B  = 32'h40000000;
        En = 1'b1;
        @(posedge clk);
        #1;
        En  = 1'b0;
        lat = 0;
        chk("busy_after_accept", 32'(Busy), 32'h1);
        chk("ready_drop_after_accept", 32'(Ready), 32'h0);
        repeat (10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        A  = 32'h40400000;
        B  = 32'h40400000;
        En = 1'b1;
        @(posedge clk);
        #1;
        En = 1'b0;
        lat++;
        chk("busy_mid_mult", 32'(Busy), 32'h1);
        while (!Ready && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("midmult_en_result", Result, 32'h40400000);
        chk("midmult_en_latency", 32'(lat), 32'(LAT_NORM));
        chk("busy_at_ready", 32'(Busy), 32'h0);

        // En held high in DONE: Ready high for exactly one cycle between operations
        @(negedge clk);
        A  = 32'hC0000000;
        B  = 32'h3F400000;
        En = 1'b1;
        @(posedge clk);
        #1;
        chk("held_en_ready_drop", 32'(Ready), 32'h0);
        lat = 0;
        while (!Ready && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("held_en_result1", Result, 32'hBFC00000);
        @(posedge clk);
        #1;
        chk("held_en_ready_one_cycle", 32'(Ready), 32'h0);
        En  = 1'b0;
        lat = 0;
        while (!Ready && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("held_en_result2", Result, 32'hBFC00000);

        // Reset mid-MULT, then a fresh operation
        @(negedge clk);
        A  = 32'h7F7FFFFF;
        B  = 32'h3F800000;
        En = 1'b1;
        @(posedge clk);
        #1;
        En = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_result", Result, 32'h0);
        chk("midreset_ready", 32'(Ready), 32'h0);
        chk("midreset_nan", 32'(NaN), 32'h0);
        chk("midreset_busy", 32'(Busy), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("after_reset_idle_ready", 32'(Ready), 32'h0);
        run_op(32'h3FC00000, 32'h40000000, res, nan, lat);
        chk("after_reset_result", res, 32'h40400000);
        chk("after_reset_latency", 32'(lat), 32'(LAT_NORM));

        // Randomized operands against the reference model
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                ra = $urandom;
                rb = $urandom;
            end else begin
                ra = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
                rb = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            end
            exp_v = ref_mul(ra, rb);
            run_op(ra, rb, res, nan, lat);
            chk($sformatf("rand%0d_result a=%h b=%h", i, ra, rb), res, exp_v[31:0]);
            chk($sformatf("rand%0d_nan", i), 32'(nan), 32'(exp_v[32]));
            if (ra[30:23] == 8'h00 || ra[30:23] == 8'hFF || rb[30:23] == 8'h00 || rb[30:23] == 8'hFF)
                chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(LAT_SPEC));
            else
                chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(LAT_NORM));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
